tile_sequencer: RTL

Control FSM that sequences one matrix tile through the systolic array. It performs four steps in order:
- fetches an N×N weight tile and latches it into the weight arranger (`weight_en`);
- holds `weight_ctr` for exactly N cycles so that N skewed weight rows shift into the PE columns;
- streams `num_rows` activation rows with stall support;
- flushes the array pipeline before signalling completion.

It sits between the top-level command interface and the weight arranger, the activation feeder and the accumulator capture logic.

---
 rtl/tpu_pkg.sv | 19 +
 rtl/tile_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array tile control path.
package tpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // Cycles needed for the last skewed partial sum to leave an NxN array.
    function automatic int DRAIN_CYCLES(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/tile_sequencer.sv
// Sequences one weight tile plus its activation rows through the systolic array:
// fetch, skewed weight shift, settle, stream with stalls, then pipeline drain.
module tile_sequencer
    import tpu_pkg::*;
#(
    parameter int N     = 4,
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             abort,
    input  logic             wt_valid,
    output logic             wt_ready,
    output logic             weight_en,
    output logic             weight_ctr,
    input  logic             act_valid,
    output logic             act_en,
    output logic             acc_flush,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(2 * N) + 1;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES(N) - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic             act_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_cnt_q <= '0;
            rows_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_cnt_q <= row_cnt_d;
            rows_q    <= rows_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        act_fire  = (state_q == S_STREAM) && act_valid;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    rows_d  = num_rows;
                end
            end
            S_FETCH:  if (wt_valid) state_d = S_SHIFT;
            // weight_ctr must stay high for the full N cycles or the arranger restarts its count
            S_SHIFT:  if (cnt_q == SHIFT_LAST) state_d = S_SETTLE;
            S_SETTLE: state_d = (rows_q == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (act_fire && (row_cnt_q == rows_q - ROW_W'(1))) state_d = S_DRAIN;
            S_DRAIN:  if (cnt_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            rows_d  = rows_q;
        end

        cnt_d     = cnt_q;
        row_cnt_d = row_cnt_q;
        if (state_q == S_SHIFT || state_q == S_DRAIN) cnt_d = cnt_q + CNT_W'(1);
        if (act_fire) row_cnt_d = row_cnt_q + ROW_W'(1);
        if (state_d != state_q || abort) begin
            cnt_d     = '0;
            row_cnt_d = '0;
        end
    end

    always_comb begin
        wt_ready   = (state_q == S_FETCH);
        weight_ctr = (state_q == S_SHIFT);
        acc_flush  = (state_q == S_DRAIN);
        done       = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        weight_en  = (state_q == S_FETCH) && wt_valid && !abort;
        act_en     = (state_q == S_STREAM) && act_valid && !abort;
    end

endmodule
